dcache_ctrl: RTL and testbench

Direct-mapped, write-through data cache controller that answers the load/store functional units' `proc2Dcache_*` requests and returns `Dcache2proc_data` / `finish`. It sits between EX and the shared memory bus. Load hits complete combinationally in the request cycle. Load misses and all stores go through a tagged, non-blocking-response memory transaction, one at a time.

---
 rtl/dcache_ctrl_pkg.sv | 46 ++++
 rtl/dcache_ctrl_if.sv | 34 +++
 rtl/dcache_mem.sv | 47 ++++
 rtl/dcache_ctrl.sv | 151 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache controller: bus encodings, access sizes,
// FSM states and the line extract / byte-mask helpers.
package dcache_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BusNone  = 2'h0,
    BusLoad  = 2'h1,
    BusStore = 2'h2
  } bus_command_e;

  typedef enum logic [1:0] {
    MemByte   = 2'h0,
    MemHalf   = 2'h1,
    MemWord   = 2'h2,
    MemDouble = 2'h3
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StLdReq,
    StLdWait,
    StStReq
  } dcache_state_e;

  // Right-align the bytes starting at 'off'; bytes past the end of the line read as zero.
  function automatic logic [XLEN-1:0] extract_word(logic [63:0] line, logic [2:0] off);
    logic [63:0] shifted;
    shifted = line >> {off, 3'b000};
    return shifted[XLEN-1:0];
  endfunction

  // Unshifted byte-enable mask for an access of the given size.
  function automatic logic [7:0] size_mask(mem_size_e size);
    logic [7:0] mask;
    unique case (size)
      MemByte: mask = 8'h01;
      MemHalf: mask = 8'h03;
      MemWord: mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Processor-side and memory-side signal bundle of the data cache controller.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  bus_command_e    proc2Dcache_command;
  logic [XLEN-1:0] proc2Dcache_addr;
  mem_size_e       proc2Dcache_size;
  logic [XLEN-1:0] proc2Dcache_data;
  logic [XLEN-1:0] Dcache2proc_data;
  logic            finish;
  bus_command_e    proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  mem_size_e       proc2mem_size;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;

  // Cache side.
  modport slave (
    input  proc2Dcache_command, proc2Dcache_addr, proc2Dcache_size, proc2Dcache_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output Dcache2proc_data, finish,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );

  // Requester plus memory side.
  modport master (
    output proc2Dcache_command, proc2Dcache_addr, proc2Dcache_size, proc2Dcache_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  Dcache2proc_data, finish,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );
endinterface

// File: rtl/dcache_mem.sv
// Valid/tag/data storage: one combinational read port, one byte-masked write port.
module dcache_mem #(
  parameter int unsigned NumLines = 32,
  parameter int unsigned IdxW     = $clog2(NumLines),
  parameter int unsigned TagW     = 24
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic            rd_valid_o,
  output logic [TagW-1:0] rd_tag_o,
  output logic [63:0]     rd_data_o,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [TagW-1:0] wr_tag_i,
  input  logic [7:0]      wr_be_i,
  input  logic [63:0]     wr_data_i
);

  logic [NumLines-1:0] valid_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [63:0]         data_q [NumLines];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Valid bits: cleared asynchronously on reset, set by any write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays; data is only meaningful behind a set valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      for (int b = 0; b < 8; b++) begin
        if (wr_be_i[b]) data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache controller with one outstanding memory transaction.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32
) (
  input  logic        clock,
  input  logic        reset,
  dcache_ctrl_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = XLEN - 3 - IdxW;

  dcache_state_e   state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  mem_size_e       size_q, size_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [3:0]      pend_tag_q, pend_tag_d;

  logic [XLEN-1:0] lookup_addr;
  logic [IdxW-1:0] lk_idx;
  logic [TagW-1:0] lk_tag;
  logic            rd_valid;
  logic [TagW-1:0] rd_tag;
  logic [63:0]     rd_data;
  logic            hit;
  logic            wr_en;
  logic [7:0]      wr_be;
  logic [63:0]     wr_data;

  // In IDLE the live request is looked up; otherwise the latched copy governs.
  assign lookup_addr = (state_q == StIdle) ? bus.proc2Dcache_addr : addr_q;
  assign lk_idx      = lookup_addr[3 +: IdxW];
  assign lk_tag      = lookup_addr[XLEN-1 -: TagW];
  assign hit         = rd_valid && (rd_tag == lk_tag);

  dcache_mem #(
    .NumLines(NUM_LINES),
    .IdxW    (IdxW),
    .TagW    (TagW)
  ) u_mem (
    .clk_i     (clock),
    .rst_i     (reset),
    .rd_idx_i  (lk_idx),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (lk_idx),
    .wr_tag_i  (lk_tag),
    .wr_be_i   (wr_be),
    .wr_data_i (wr_data)
  );

  // State and request latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      size_q     <= MemByte;
      data_q     <= '0;
      pend_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      data_q     <= data_d;
      pend_tag_q <= pend_tag_d;
    end
  end

  // Next state, bus drive, cache writes and processor response.
  always_comb begin
    state_d               = state_q;
    addr_d                = addr_q;
    size_d                = size_q;
    data_d                = data_q;
    pend_tag_d            = pend_tag_q;
    bus.finish            = 1'b0;
    bus.Dcache2proc_data  = '0;
    bus.proc2mem_command  = BusNone;
    bus.proc2mem_addr     = '0;
    bus.proc2mem_data     = '0;
    bus.proc2mem_size     = MemDouble;
    wr_en                 = 1'b0;
    wr_be                 = '0;
    wr_data               = '0;
    unique case (state_q)
      StIdle: begin
        case (bus.proc2Dcache_command)
          BusLoad: begin
            if (hit) begin
              bus.finish           = 1'b1;
              bus.Dcache2proc_data = extract_word(rd_data, lookup_addr[2:0]);
            end else begin
              addr_d  = bus.proc2Dcache_addr;
              size_d  = bus.proc2Dcache_size;
              state_d = StLdReq;
            end
          end
          BusStore: begin
            addr_d  = bus.proc2Dcache_addr;
            size_d  = bus.proc2Dcache_size;
            data_d  = bus.proc2Dcache_data;
            state_d = StStReq;
          end
          default: ;
        endcase
      end
      StLdReq: begin
        bus.proc2mem_command = BusLoad;
        bus.proc2mem_addr    = {addr_q[XLEN-1:3], 3'b000};
        bus.proc2mem_size    = MemDouble;
        if (bus.mem2proc_response != 4'd0) begin
          pend_tag_d = bus.mem2proc_response;
          state_d    = StLdWait;
        end
      end
      StLdWait: begin
        // pend_tag_q is never zero here, so an idle tag bus cannot match.
        if (bus.mem2proc_tag == pend_tag_q) begin
          bus.finish           = 1'b1;
          bus.Dcache2proc_data = extract_word(bus.mem2proc_data, lookup_addr[2:0]);
          wr_en                = 1'b1;
          wr_be                = 8'hFF;
          wr_data              = bus.mem2proc_data;
          state_d              = StIdle;
        end
      end
      StStReq: begin
        bus.proc2mem_command = BusStore;
        bus.proc2mem_addr    = addr_q;
        bus.proc2mem_size    = size_q;
        bus.proc2mem_data    = {{(64-XLEN){1'b0}}, data_q};
        if (bus.mem2proc_response != 4'd0) begin
          bus.finish = 1'b1;
          // Write-through, no allocate: only a resident line is updated.
          if (hit) begin
            wr_en   = 1'b1;
            wr_be   = size_mask(size_q) << lookup_addr[2:0];
            wr_data = {{(64-XLEN){1'b0}}, data_q} << {lookup_addr[2:0], 3'b000};
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  dcache_ctrl_if bus ();

  dcache_ctrl #(
    .NUM_LINES(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(bus_command_e c, logic [31:0] a, mem_size_e s, logic [31:0] d);
    bus.proc2Dcache_command = c;
    bus.proc2Dcache_addr    = a;
    bus.proc2Dcache_size    = s;
    bus.proc2Dcache_data    = d;
  endtask

  task automatic mem(logic [3:0] resp, logic [3:0] tag, logic [63:0] data);
    bus.mem2proc_response = resp;
    bus.mem2proc_tag      = tag;
    bus.mem2proc_data     = data;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(BusNone, 32'h0, MemByte, 32'h0);
    mem(4'd0, 4'd0, 64'h0);
    repeat (2) @(negedge clock);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL rst_finish: got %b want 0", bus.finish); end
    total++; if (bus.Dcache2proc_data !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.Dcache2proc_data); end
    total++; if (bus.proc2mem_command !== BusNone) begin bad++; $display("FAIL rst_cmd: got %0d want 0", bus.proc2mem_command); end
    total++; if (bus.proc2mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.proc2mem_addr); end
    total++; if (bus.proc2mem_data !== 64'h0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.proc2mem_data); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_cold_load;
    @(negedge clock);
    drive(BusLoad, 32'h1004, MemWord, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL cold_miss: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd3, 4'd0, 64'h0);
    #1;
    total++; if (bus.proc2mem_command !== BusLoad) begin bad++; $display("FAIL cold_cmd: got %0d want 1", bus.proc2mem_command); end
    total++; if (bus.proc2mem_addr !== 32'h1000) begin bad++; $display("FAIL cold_addr: got %h want 1000", bus.proc2mem_addr); end
    total++; if (bus.proc2mem_size !== MemDouble) begin bad++; $display("FAIL cold_size: got %0d want 3", bus.proc2mem_size); end
    @(negedge clock);
    mem(4'd0, 4'd3, 64'h11223344_55667788);
    #1;
    total++; if (bus.proc2mem_command !== BusNone) begin bad++; $display("FAIL cold_wait_cmd: got %0d want 0", bus.proc2mem_command); end
    total++; if (bus.finish !== 1'b1) begin bad++; $display("FAIL cold_finish: got %b want 1", bus.finish); end
    total++; if (bus.Dcache2proc_data !== 32'h11223344) begin bad++; $display("FAIL cold_rdata: got %h want 11223344", bus.Dcache2proc_data); end
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    #1;
    total++; if (bus.finish !== 1'b1) begin bad++; $display("FAIL rehit_finish: got %b want 1", bus.finish); end
    total++; if (bus.Dcache2proc_data !== 32'h11223344) begin bad++; $display("FAIL rehit_rdata: got %h want 11223344", bus.Dcache2proc_data); end
    drive(BusNone, 32'h0, MemByte, 32'h0);
    #1;
    total++; if (bus.Dcache2proc_data !== 32'h0) begin bad++; $display("FAIL idle_rdata: got %h want 0", bus.Dcache2proc_data); end
  endtask

  task automatic test_rejected;
    @(negedge clock);
    drive(BusLoad, 32'h1010, MemWord, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL rej_miss: got %b want 0", bus.finish); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      mem(4'd0, 4'd0, 64'h0);
      #1;
      total++; if (bus.proc2mem_command !== BusLoad) begin bad++; $display("FAIL rej_hold%0d: got %0d want 1", i, bus.proc2mem_command); end
    end
    @(negedge clock);
    // Tag alongside the acceptance cannot complete the load.
    mem(4'd5, 4'd5, 64'hFFFFFFFF_FFFFFFFF);
    #1;
    total++; if (bus.proc2mem_command !== BusLoad) begin bad++; $display("FAIL rej_accept_cmd: got %0d want 1", bus.proc2mem_command); end
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL rej_same_cycle_tag: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd0, 4'd2, 64'h01234567_89ABCDEF);
    #1;
    total++; if (bus.proc2mem_command !== BusNone) begin bad++; $display("FAIL rej_wait_cmd: got %0d want 0", bus.proc2mem_command); end
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL rej_stray_tag: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd0, 4'd5, 64'hAAAABBBB_CCCCDDDD);
    #1;
    total++; if (bus.finish !== 1'b1) begin bad++; $display("FAIL rej_finish: got %b want 1", bus.finish); end
    total++; if (bus.Dcache2proc_data !== 32'hCCCCDDDD) begin bad++; $display("FAIL rej_rdata: got %h want ccccdddd", bus.Dcache2proc_data); end
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    drive(BusNone, 32'h0, MemByte, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL rej_one_cycle: got %b want 0", bus.finish); end
  endtask

  task automatic test_store_hit;
    @(negedge clock);
    drive(BusStore, 32'h1006, MemByte, 32'h000000AB);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL st_early_finish: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd7, 4'd0, 64'h0);
    #1;
    total++; if (bus.proc2mem_command !== BusStore) begin bad++; $display("FAIL st_cmd: got %0d want 2", bus.proc2mem_command); end
    total++; if (bus.proc2mem_addr !== 32'h1006) begin bad++; $display("FAIL st_addr: got %h want 1006", bus.proc2mem_addr); end
    total++; if (bus.proc2mem_size !== MemByte) begin bad++; $display("FAIL st_size: got %0d want 0", bus.proc2mem_size); end
    total++; if (bus.proc2mem_data !== 64'hAB) begin bad++; $display("FAIL st_data: got %h want ab", bus.proc2mem_data); end
    total++; if (bus.finish !== 1'b1) begin bad++; $display("FAIL st_finish: got %b want 1", bus.finish); end
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    drive(BusLoad, 32'h1006, MemHalf, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b1) begin bad++; $display("FAIL merge_hit: got %b want 1", bus.finish); end
    total++; if (bus.Dcache2proc_data !== 32'h000011AB) begin bad++; $display("FAIL merge_half: got %h want 000011ab", bus.Dcache2proc_data); end
    drive(BusLoad, 32'h1004, MemWord, 32'h0);
    #1;
    total++; if (bus.Dcache2proc_data !== 32'h11AB3344) begin bad++; $display("FAIL merge_word: got %h want 11ab3344", bus.Dcache2proc_data); end
    drive(BusNone, 32'h0, MemByte, 32'h0);
  endtask

  task automatic test_store_miss;
    @(negedge clock);
    drive(BusStore, 32'h2000, MemWord, 32'hDEADBEEF);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL stm_early_finish: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd1, 4'd0, 64'h0);
    #1;
    total++; if (bus.proc2mem_data !== 64'h00000000_DEADBEEF) begin bad++; $display("FAIL stm_data: got %h want deadbeef", bus.proc2mem_data); end
    total++; if (bus.proc2mem_size !== MemWord) begin bad++; $display("FAIL stm_size: got %0d want 2", bus.proc2mem_size); end
    total++; if (bus.finish !== 1'b1) begin bad++; $display("FAIL stm_finish: got %b want 1", bus.finish); end
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    drive(BusLoad, 32'h2000, MemWord, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL stm_no_alloc: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd2, 4'd0, 64'h0);
    #1;
    total++; if (bus.proc2mem_addr !== 32'h2000) begin bad++; $display("FAIL stm_fill_addr: got %h want 2000", bus.proc2mem_addr); end
    @(negedge clock);
    mem(4'd0, 4'd2, 64'h00000000_99887766);
    #1;
    total++; if (bus.Dcache2proc_data !== 32'h99887766) begin bad++; $display("FAIL stm_fill_rdata: got %h want 99887766", bus.Dcache2proc_data); end
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    drive(BusNone, 32'h0, MemByte, 32'h0);
  endtask

  task automatic test_conflict;
    @(negedge clock);
    drive(BusLoad, 32'h1000, MemWord, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL cf_evicted: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd6, 4'd0, 64'h0);
    @(negedge clock);
    mem(4'd0, 4'd6, 64'h11223344_55667788);
    #1;
    total++; if (bus.Dcache2proc_data !== 32'h55667788) begin bad++; $display("FAIL cf_fill_a: got %h want 55667788", bus.Dcache2proc_data); end
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    drive(BusLoad, 32'h1100, MemWord, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL cf_b_miss: got %b want 0", bus.finish); end
    @(negedge clock);
    mem(4'd7, 4'd0, 64'h0);
    @(negedge clock);
    mem(4'd0, 4'd7, 64'hCAFEF00D_12345678);
    #1;
    total++; if (bus.Dcache2proc_data !== 32'h12345678) begin bad++; $display("FAIL cf_fill_b: got %h want 12345678", bus.Dcache2proc_data); end
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    drive(BusLoad, 32'h1000, MemWord, 32'h0);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL cf_a_miss: got %b want 0", bus.finish); end
    drive(BusLoad, 32'h1104, MemWord, 32'h0);
    #1;
    total++; if (bus.Dcache2proc_data !== 32'hCAFEF00D) begin bad++; $display("FAIL cf_b_hit: got %h want cafef00d", bus.Dcache2proc_data); end
    drive(BusNone, 32'h0, MemByte, 32'h0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] probes [5];
    probes = '{32'h1000, 32'h1100, 32'h1010, 32'h2000, 32'h1018};
    @(negedge clock);
    drive(BusLoad, 32'h1018, MemWord, 32'h0);
    @(negedge clock);
    mem(4'd4, 4'd0, 64'h0);
    @(negedge clock);
    mem(4'd0, 4'd0, 64'h0);
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL mid_finish: got %b want 0", bus.finish); end
    total++; if (bus.proc2mem_command !== BusNone) begin bad++; $display("FAIL mid_cmd: got %0d want 0", bus.proc2mem_command); end
    total++; if (bus.proc2mem_addr !== 32'h0) begin bad++; $display("FAIL mid_addr: got %h want 0", bus.proc2mem_addr); end
    drive(BusNone, 32'h0, MemByte, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    mem(4'd0, 4'd4, 64'h55555555_66666666);
    #1;
    total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL mid_late_tag: got %b want 0", bus.finish); end
    total++; if (bus.Dcache2proc_data !== 32'h0) begin bad++; $display("FAIL mid_late_rdata: got %h want 0", bus.Dcache2proc_data); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      mem(4'd0, 4'd0, 64'h0);
      drive(BusLoad, probes[i], MemWord, 32'h0);
      #1;
      total++; if (bus.finish !== 1'b0) begin bad++; $display("FAIL mid_cold_%0d: got %b want 0", i, bus.finish); end
      drive(BusNone, 32'h0, MemByte, 32'h0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cold_load();
    test_rejected();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
